// File: rtl/weight_streamer.sv
// ---------------------------------------------------------------------------
// weight_streamer
//
// Streams numWeight consecutive words out of a synchronous-read weight memory
// to a valid/ready consumer. Each start request runs one pass: addresses
// 0..numWeight-1 are issued in order, the returned words are parked in a
// 2-entry FIFO and presented to the consumer from the FIFO head. Address
// issue is throttled so that buffered plus in-flight words never exceed two,
// which lets a held-high w_ready drain one beat per cycle with no bubbles.
//
// Parameters
//   numWeight    : weights per pass (1 .. 2^(addressWidth+1))
//   addressWidth : read address is addressWidth+1 bits wide
//   dataWidth    : weight word width
//
// Ports
//   CLK      in   clock, all state changes on the rising edge
//   RESET    in   synchronous active-high reset
//   start    in   request one pass (only honoured while idle)
//   radd     out  read address to the weight memory
//   wout     in   memory data for the address presented one edge earlier
//   w_data   out  weight presented to the consumer
//   w_valid  out  w_data holds a valid weight
//   w_ready  in   consumer accepts the current beat
//   w_last   out  current beat is the final weight of the pass
//   busy     out  a pass is in progress
//   done     out  one-cycle pulse after the final beat transfers
// ---------------------------------------------------------------------------
module weight_streamer #(
    parameter int numWeight    = 3,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   start,
    output logic [addressWidth:0]  radd,
    input  logic [dataWidth-1:0]   wout,
    output logic [dataWidth-1:0]   w_data,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic                   w_last,
    output logic                   busy,
    output logic                   done
);

    localparam int AW = addressWidth + 1;
    localparam logic [AW-1:0] LAST_INDEX = AW'(numWeight - 1);
    localparam logic [AW-1:0] ONE        = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_t;

    state_t state;
    state_t state_next;

    logic [AW-1:0]        issue_addr;
    logic [AW-1:0]        last_addr;
    logic [AW-1:0]        beat_count;
    logic                 in_flight;

    logic [dataWidth-1:0] fifo_mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           occupancy;

    logic                 pop;
    logic                 issue;
    logic                 final_beat;
    logic [2:0]           pending;

    // Consumer-side view of the FIFO head. w_data is forced to zero while
    // empty so stale FIFO contents never leak out after reset.
    assign w_valid    = (occupancy != 2'd0);
    assign w_data     = w_valid ? fifo_mem[rd_ptr] : '0;
    assign w_last     = w_valid && (beat_count == LAST_INDEX);
    assign pop        = w_valid && w_ready;
    assign final_beat = pop && w_last;
    assign busy       = (state != IDLE);

    // Words that will still be held after this cycle's pop. Issuing only
    // when this is at most one keeps buffered + in-flight within the FIFO.
    assign pending = {1'b0, occupancy} + {2'b00, in_flight} - {2'b00, pop};

    // The address is presented combinationally in the issuing cycle; in all
    // other cycles radd keeps showing the most recently issued address.
    assign radd = issue ? issue_addr : last_addr;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                issue = (pending <= 3'd1);
                if (issue && (issue_addr == LAST_INDEX)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (final_beat) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address generation: issue_addr is the next address to send, last_addr
    // remembers what radd shows between issues.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            issue_addr <= '0;
            last_addr  <= '0;
        end else if ((state == IDLE) && start) begin
            issue_addr <= '0;
        end else if (issue) begin
            last_addr  <= issue_addr;
            issue_addr <= issue_addr + ONE;
        end
    end

    // One-cycle marker that memory data for an issued address arrives on
    // wout in the next cycle and must be captured.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            in_flight <= 1'b0;
        end else begin
            in_flight <= issue;
        end
    end

    // FIFO storage has no reset; validity is tracked by occupancy alone.
    always_ff @(posedge CLK) begin
        if (in_flight) begin
            fifo_mem[wr_ptr] <= wout;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (in_flight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occupancy <= occupancy + {1'b0, in_flight} - {1'b0, pop};
        end
    end

    // Beat counter restarts on the final transfer so a following pass
    // begins at index zero without extra bookkeeping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            beat_count <= '0;
        end else if (final_beat) begin
            beat_count <= '0;
        end else if (pop) begin
            beat_count <= beat_count + ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            done <= 1'b0;
        end else begin
            done <= final_beat;
        end
    end

endmodule

// File: tb/tb_weight_streamer.sv
// ---------------------------------------------------------------------------
// tb_weight_streamer
//
// Drives a 4-weight streamer and a 1-weight streamer against behavioural
// synchronous-read memories. Expected beats come from the memory contents in
// index order; timing expectations come from the pass-level rules (first
// beat two cycles after start, valid held until all beats are taken, done
// the cycle after the last transfer).
// ---------------------------------------------------------------------------
module tb_weight_streamer;

    localparam int N    = 4;
    localparam int AWID = 3;
    localparam int DW   = 16;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            start;
    logic            w_ready;
    logic [AWID:0]   radd;
    logic [DW-1:0]   wout;
    logic [DW-1:0]   w_data;
    logic            w_valid;
    logic            w_last;
    logic            busy;
    logic            done;

    logic            start1;
    logic            ready1;
    logic [AWID:0]   radd1;
    logic [DW-1:0]   wout1;
    logic [DW-1:0]   w_data1;
    logic            w_valid1;
    logic            w_last1;
    logic            busy1;
    logic            done1;

    logic [DW-1:0]   mem [16];
    int              total = 0;
    int              bad   = 0;

    weight_streamer #(
        .numWeight(N), .addressWidth(AWID), .dataWidth(DW)
    ) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .radd(radd), .wout(wout),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .w_last(w_last), .busy(busy), .done(done)
    );

    weight_streamer #(
        .numWeight(1), .addressWidth(AWID), .dataWidth(DW)
    ) dut1 (
        .CLK(CLK), .RESET(RESET), .start(start1), .radd(radd1), .wout(wout1),
        .w_data(w_data1), .w_valid(w_valid1), .w_ready(ready1),
        .w_last(w_last1), .busy(busy1), .done(done1)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read memories: data for the address seen at an edge
    // appears after that edge.
    always @(posedge CLK) begin
        wout  <= mem[radd];
        wout1 <= (radd1 == '0) ? 16'h0ABC : 16'hDEAD;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r);
        start   = s;
        w_ready = r;
    endtask

    // One pass. mode: 0 ready high, 1 ready low until cycle 10, 2 ready
    // toggling, 3 random ready. preStarted means start was already sampled
    // and we are in cycle 0. chainNext raises start in the done cycle.
    task automatic runPass(input int mode, input bit preStarted,
                           input bit midPulse, input bit chainNext);
        int  beat      = 0;
        int  cyc       = 0;
        int  firstXfer = -1;
        int  lastXfer  = -1;
        bit  seenDone  = 1'b0;
        bit  expValid;
        logic r;
        logic s;
        if (!preStarted) begin
            applyStimulus(1'b1, 1'b0);
            @(posedge CLK); #1;
        end
        while (!seenDone && cyc < 100) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc >= 10);
                2:       r = (cyc % 2 == 0);
                default: r = ($urandom_range(0, 2) != 0);
            endcase
            s = (midPulse && cyc == 3) ||
                (chainNext && lastXfer >= 0 && cyc == lastXfer + 1);
            applyStimulus(s, r);
            @(negedge CLK);
            if (lastXfer >= 0 && cyc == lastXfer + 1) begin
                checkOutput($sformatf("done c%0d", cyc), done, 1);
                checkOutput($sformatf("busy_done c%0d", cyc), busy, 0);
                checkOutput($sformatf("valid_done c%0d", cyc), w_valid, 0);
                seenDone = 1'b1;
            end else begin
                expValid = (cyc >= 2) && (beat < N);
                checkOutput($sformatf("done_low c%0d", cyc), done, 0);
                checkOutput($sformatf("busy c%0d", cyc), busy, 1);
                checkOutput($sformatf("valid c%0d", cyc), w_valid, expValid);
                if (expValid) begin
                    checkOutput($sformatf("data c%0d", cyc), w_data, mem[beat]);
                    checkOutput($sformatf("last c%0d", cyc), w_last, (beat == N - 1));
                    if (r) begin
                        if (firstXfer < 0) firstXfer = cyc;
                        if (beat == N - 1) lastXfer = cyc;
                        beat++;
                    end
                end else begin
                    checkOutput($sformatf("last_idle c%0d", cyc), w_last, 0);
                end
                if (mode == 0 && cyc <= 3)
                    checkOutput($sformatf("radd c%0d", cyc), radd, cyc);
                if (mode == 1 && cyc <= 9)
                    checkOutput($sformatf("radd_stall c%0d", cyc), radd, (cyc == 0) ? 0 : 1);
            end
            @(posedge CLK); #1;
            cyc++;
        end
        if (!seenDone) checkOutput("pass_timeout", 0, 1);
        checkOutput("beat_count", beat, N);
        if (mode == 0) begin
            checkOutput("first_beat_cycle", firstXfer, 2);
            checkOutput("last_beat_cycle", lastXfer, 5);
        end
        if (!chainNext) applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        bit ch;
        bit nextCh;
        RESET  = 1'b1;
        start1 = 1'b0;
        ready1 = 1'b1;
        applyStimulus(1'b1, 1'b0);
        mem[0] = 16'h0011; mem[1] = 16'h0022; mem[2] = 16'h0033; mem[3] = 16'h0044;
        for (int i = 4; i < 16; i++) mem[i] = 16'hBAD0 + 16'(i);

        // Reset dominates a simultaneous start.
        repeat (3) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_valid", w_valid, 0);
            checkOutput("rst_last", w_last, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_data", w_data, 0);
            checkOutput("rst_radd", radd, 0);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        applyStimulus(1'b0, 1'b0);
        @(posedge CLK); #1;

        runPass(0, 1'b0, 1'b0, 1'b0);
        runPass(1, 1'b0, 1'b0, 1'b0);
        runPass(2, 1'b0, 1'b0, 1'b0);
        runPass(0, 1'b0, 1'b1, 1'b1);
        runPass(0, 1'b1, 1'b0, 1'b0);

        // Reset in cycle 3 of a pass, with start also high.
        applyStimulus(1'b1, 1'b1);
        @(posedge CLK); #1;
        applyStimulus(1'b0, 1'b1);
        repeat (3) begin @(posedge CLK); #1; end
        RESET = 1'b1;
        applyStimulus(1'b1, 1'b1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        applyStimulus(1'b0, 1'b0);
        @(negedge CLK);
        checkOutput("midrst_valid", w_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_radd", radd, 0);
        checkOutput("midrst_done", done, 0);
        @(posedge CLK); #1;
        runPass(0, 1'b0, 1'b0, 1'b0);

        // Single-weight build.
        start1 = 1'b1;
        @(posedge CLK); #1;
        start1 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            checkOutput($sformatf("nw1_valid c%0d", c), w_valid1, (c == 2));
            checkOutput($sformatf("nw1_last c%0d", c), w_last1, (c == 2));
            checkOutput($sformatf("nw1_done c%0d", c), done1, (c == 3));
            checkOutput($sformatf("nw1_busy c%0d", c), busy1, (c < 3));
            if (c == 2) checkOutput("nw1_data", w_data1, 16'h0ABC);
            if (c == 0) checkOutput("nw1_radd", radd1, 0);
            @(posedge CLK); #1;
        end

        // Random backpressure and random back-to-back chaining.
        ch = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N; k++) mem[k] = 16'($urandom);
            nextCh = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
            runPass(3, ch, 1'($urandom_range(0, 1)), nextCh);
            ch = nextCh;
        end

        repeat (2) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
